// File: rtl/rvfi_commit_sequencer.sv
// rvfi_commit_sequencer
//   Multi-lane retirement sequencer for the RVFI verification top. It accepts up
//   to NUM_LANES retirements per cycle (lane 0 oldest). Each accepted retirement
//   gets a monotonically increasing order tag. A halt (explicit flag or
//   self-loop pc_rdata==pc_wdata) lets the halting lane and older lanes commit,
//   squashes younger lanes, then drains for HALT_DRAIN cycles before raising done.
//   A no-commit watchdog raises timeout after TIMEOUT_CYCLES idle RUN cycles.
//
//   Optional build macro COMMIT_STATS_EN adds commit-width histogram and
//   maximum-idle statistics outputs.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   commit_valid[L]   lane i retires an instruction this cycle
//   halt_req[L]       explicit halt flag for lane i
//   pc_rdata[L*32]    PC of retiring instruction, lane i at [32i+:32]
//   pc_wdata[L*32]    next PC of lane i
//   lane_commit[L]    accepted commit per lane (combinational)
//   lane_order[L*OW]  order tag per lane (combinational, valid with lane_commit)
//   order_next[OW]    registered count of accepted commits
//   halted/done/timeout  sticky status flags
//   dbg_state[2]      FSM state (0 RUN, 1 DRAIN, 2 DONE, 3 TIMEOUT)
//   lane_hist, max_idle  (COMMIT_STATS_EN only) commit statistics
//
// Handshake: there is no backpressure. A lane retirement is an unconditional
// offer; lane_commit reports whether the sequencer accepted it that cycle.
module rvfi_commit_sequencer #(
  parameter int NUM_LANES      = 2,
  parameter int ORDER_W        = 64,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int HALT_DRAIN     = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_LANES-1:0]         commit_valid,
  input  logic [NUM_LANES-1:0]         halt_req,
  input  logic [NUM_LANES*32-1:0]      pc_rdata,
  input  logic [NUM_LANES*32-1:0]      pc_wdata,
  output logic [NUM_LANES-1:0]         lane_commit,
  output logic [NUM_LANES*ORDER_W-1:0] lane_order,
  output logic [ORDER_W-1:0]           order_next,
  output logic                         halted,
  output logic                         done,
  output logic                         timeout,
  output logic [1:0]                   dbg_state
`ifdef COMMIT_STATS_EN
  ,
  output logic [NUM_LANES:0][31:0]     lane_hist,
  output logic [31:0]                  max_idle
`endif
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_DRAIN   = 2'd1,
    S_DONE    = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  localparam int IDLE_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int DRAIN_W = (HALT_DRAIN > 1) ? $clog2(HALT_DRAIN) : 1;
  localparam int CNT_W   = $clog2(NUM_LANES + 1);
  localparam logic [IDLE_W-1:0]  IDLE_MAX  = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_MAX = DRAIN_W'(HALT_DRAIN - 1);

  state_t               r_state, w_state_n;
  logic [ORDER_W-1:0]   r_order, w_order_n;
  logic [IDLE_W-1:0]    r_idle, w_idle_n;
  logic [DRAIN_W-1:0]   r_drain, w_drain_n;
  logic                 r_halted, w_halted_n;
  logic                 r_done, w_done_n;
  logic                 r_timeout, w_timeout_n;

  logic                 w_in_run;
  logic [NUM_LANES-1:0] w_hit;
  logic                 w_blocked;
  logic [ORDER_W-1:0]   w_run;
  logic [CNT_W-1:0]     w_ncommit;
  logic [NUM_LANES-1:0] w_lane_commit;
  logic [NUM_LANES*ORDER_W-1:0] w_lane_order;
  logic                 w_any_hit;
  logic                 w_any_commit;

  // Commits are only accepted in RUN, and never while reset is asserted.
  assign w_in_run = (r_state == S_RUN) & ~rst;

  // Lane acceptance and order tagging. w_blocked goes high once an older lane
  // has hit a halt; every younger lane after that is squashed. The running
  // sum w_run is the popcount of accepted older lanes.
  always_comb begin
    w_hit         = '0;
    w_blocked     = 1'b0;
    w_run         = '0;
    w_ncommit     = '0;
    w_lane_commit = '0;
    w_lane_order  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_hit[i] = commit_valid[i] &
                 (halt_req[i] | (pc_rdata[32*i +: 32] == pc_wdata[32*i +: 32]));
      w_lane_commit[i] = w_in_run & commit_valid[i] & ~w_blocked;
      w_lane_order[ORDER_W*i +: ORDER_W] = r_order + w_run;
      if (w_lane_commit[i]) begin
        w_run     = w_run + ORDER_W'(1);
        w_ncommit = w_ncommit + CNT_W'(1);
      end
      w_blocked = w_blocked | w_hit[i];
    end
  end

  assign w_any_hit    = w_in_run & (|w_hit);
  assign w_any_commit = |w_lane_commit;

  // Next-state and status logic.
  always_comb begin
    w_state_n   = r_state;
    w_order_n   = r_order + w_run;
    w_idle_n    = r_idle;
    w_drain_n   = r_drain;
    w_halted_n  = r_halted;
    w_done_n    = r_done;
    w_timeout_n = r_timeout;
    case (r_state)
      S_RUN: begin
        if (w_any_hit) begin
          // Halt wins over a watchdog expiry in the same cycle.
          w_state_n  = S_DRAIN;
          w_halted_n = 1'b1;
          w_drain_n  = '0;
        end else if (w_any_commit) begin
          w_idle_n = '0;
        end else if (r_idle == IDLE_MAX) begin
          w_state_n   = S_TIMEOUT;
          w_timeout_n = 1'b1;
        end else begin
          w_idle_n = r_idle + IDLE_W'(1);
        end
      end
      S_DRAIN: begin
        if (r_drain == DRAIN_MAX) begin
          w_state_n = S_DONE;
          w_done_n  = 1'b1;
        end else begin
          w_drain_n = r_drain + DRAIN_W'(1);
        end
      end
      default: begin
        // DONE and TIMEOUT are terminal until reset.
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_RUN;
      r_order   <= '0;
      r_idle    <= '0;
      r_drain   <= '0;
      r_halted  <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_order   <= w_order_n;
      r_idle    <= w_idle_n;
      r_drain   <= w_drain_n;
      r_halted  <= w_halted_n;
      r_done    <= w_done_n;
      r_timeout <= w_timeout_n;
    end
  end

  assign lane_commit = w_lane_commit;
  assign lane_order  = w_lane_order;
  assign order_next  = r_order;
  assign halted      = r_halted;
  assign done        = r_done;
  assign timeout     = r_timeout;
  assign dbg_state   = r_state;

`ifdef COMMIT_STATS_EN
  logic [NUM_LANES:0][31:0] r_hist;
  logic [31:0]              r_max_idle;

  // Histogram bin k counts RUN cycles with exactly k accepted lanes; bins
  // saturate rather than wrap. Both statistics freeze outside RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist     <= '0;
      r_max_idle <= '0;
    end else if (r_state == S_RUN) begin
      for (int k = 0; k <= NUM_LANES; k++) begin
        if ((int'(w_ncommit) == k) && (r_hist[k] != 32'hFFFF_FFFF))
          r_hist[k] <= r_hist[k] + 32'd1;
      end
      if (32'(r_idle) > r_max_idle)
        r_max_idle <= 32'(r_idle);
    end
  end

  assign lane_hist = r_hist;
  assign max_idle  = r_max_idle;
`endif

endmodule
